// File: rtl/t_toggle_monitor.sv
// t_toggle_monitor: synchronises the toggle input T_in, counts its rising edges modulo MOD, measures rise-to-rise period and flags a stalled source
// Ports:
//   Clock        system clock, rising edge
//   Reset        asynchronous active-high reset
//   T_in         asynchronous toggle input
//   En           count enable (gates Count and Tc only)
//   Clr          synchronous clear, highest priority
//   Count        modulo-MOD rise count
//   Tc           one-cycle terminal-count pulse
//   Period       cycles between the last two rises (saturating)
//   Period_valid Period is a genuine rise-to-rise measurement (RUN state)
//   Stall        no rise seen for TIMEOUT cycles
module t_toggle_monitor #(
  parameter int WIDTH   = 4,
  parameter int MOD     = 10,
  parameter int PW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             T_in,
  input  logic             En,
  input  logic             Clr,
  output logic [WIDTH-1:0] Count,
  output logic             Tc,
  output logic [PW-1:0]    Period,
  output logic             Period_valid,
  output logic             Stall
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN, STALL} state_t;
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);
  localparam logic [PW-1:0] TO_LAST = PW'(TIMEOUT - 1);
  state_t state;
  logic s0, s1, prev;
  logic [PW-1:0] g, g_inc;
  logic rise, timeout;
  assign rise = s1 & ~prev;
  assign g_inc = (g == '1) ? g : g + PW'(1);
  // G counts completed rise-free cycles, so reaching TIMEOUT-1 here means the next edge is the TIMEOUT-th
  assign timeout = (g == TO_LAST) & ~rise;
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      prev <= 1'b0;
      Count <= '0;
      Tc <= 1'b0;
      g <= '0;
      Period <= '0;
      Period_valid <= 1'b0;
      Stall <= 1'b0;
      state <= IDLE;
    end else begin
      s0 <= T_in;
      s1 <= s0;
      prev <= s1;
      if (Clr) begin
        Count <= '0;
        Tc <= 1'b0;
        g <= '0;
        Period <= '0;
        Period_valid <= 1'b0;
        Stall <= 1'b0;
        state <= IDLE;
      end else begin
        Tc <= rise & En & (Count == LAST);
        if (rise & En) Count <= (Count == LAST) ? '0 : Count + WIDTH'(1);
        g <= rise ? '0 : g_inc;
        if (rise) Period <= g_inc;
        case (state)
          IDLE: if (rise) state <= ARMED;
          ARMED:
            if (rise) begin
              state <= RUN;
              Period_valid <= 1'b1;
            end else if (timeout) begin
              state <= STALL;
              Stall <= 1'b1;
            end
          RUN:
            if (timeout) begin
              state <= STALL;
              Period_valid <= 1'b0;
              Stall <= 1'b1;
            end
          STALL:
            if (rise) begin
              state <= ARMED;
              Stall <= 1'b0;
            end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_t_toggle_monitor.sv
// tb_t_toggle_monitor: table-driven directed bench for t_toggle_monitor with default parameters
module tb_t_toggle_monitor;
  logic Clock, Reset, T_in, En, Clr;
  logic [3:0] Count;
  logic Tc, Period_valid, Stall;
  logic [7:0] Period;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic t, en, clr;
    int n;
    int c;
    logic tc;
    int p;
    logic pv, st;
  } vec_t;
  vec_t tbl[$];

  t_toggle_monitor dut (
    .Clock(Clock), .Reset(Reset), .T_in(T_in), .En(En), .Clr(Clr),
    .Count(Count), .Tc(Tc), .Period(Period), .Period_valid(Period_valid), .Stall(Stall)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int tc, input int p, input int pv, input int st);
    chk({tag, " Count"}, Count, c);
    chk({tag, " Tc"}, Tc, tc);
    chk({tag, " Period"}, Period, p);
    chk({tag, " Period_valid"}, Period_valid, pv);
    chk({tag, " Stall"}, Stall, st);
  endtask

  // rise high for 3 edges (processed on the 3rd), then low for lo edges
  task automatic pulse(input int lo);
    T_in = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    T_in = 1'b0;
    repeat (lo) @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    // fields: t_in, en, clr, edges, Count, Tc, Period, Period_valid, Stall
    tbl.push_back('{0, 1, 1, 1, 0, 0, 0, 0, 0});
    // period-10 square wave, wrap at MOD=10
    tbl.push_back('{1, 1, 0, 3, 1, 0, 3, 0, 0});
    tbl.push_back('{0, 1, 0, 7, 1, 0, 3, 0, 0});
    tbl.push_back('{1, 1, 0, 3, 2, 0, 10, 1, 0});
    tbl.push_back('{0, 1, 0, 7, 2, 0, 10, 1, 0});
    tbl.push_back('{1, 1, 0, 3, 3, 0, 10, 1, 0});
    tbl.push_back('{0, 1, 0, 7, 3, 0, 10, 1, 0});
    tbl.push_back('{1, 1, 0, 3, 4, 0, 10, 1, 0});
    tbl.push_back('{0, 1, 0, 7, 4, 0, 10, 1, 0});
    tbl.push_back('{1, 1, 0, 3, 5, 0, 10, 1, 0});
    tbl.push_back('{0, 1, 0, 7, 5, 0, 10, 1, 0});
    tbl.push_back('{1, 1, 0, 3, 6, 0, 10, 1, 0});
    tbl.push_back('{0, 1, 0, 7, 6, 0, 10, 1, 0});
    tbl.push_back('{1, 1, 0, 3, 7, 0, 10, 1, 0});
    tbl.push_back('{0, 1, 0, 7, 7, 0, 10, 1, 0});
    tbl.push_back('{1, 1, 0, 3, 8, 0, 10, 1, 0});
    tbl.push_back('{0, 1, 0, 7, 8, 0, 10, 1, 0});
    tbl.push_back('{1, 1, 0, 3, 9, 0, 10, 1, 0});
    tbl.push_back('{0, 1, 0, 7, 9, 0, 10, 1, 0});
    tbl.push_back('{1, 1, 0, 3, 0, 1, 10, 1, 0});
    tbl.push_back('{0, 1, 0, 1, 0, 0, 10, 1, 0});
    tbl.push_back('{0, 1, 0, 6, 0, 0, 10, 1, 0});
    // period 12
    tbl.push_back('{1, 1, 0, 3, 1, 0, 10, 1, 0});
    tbl.push_back('{0, 1, 0, 9, 1, 0, 10, 1, 0});
    tbl.push_back('{1, 1, 0, 3, 2, 0, 12, 1, 0});
    tbl.push_back('{0, 1, 0, 9, 2, 0, 12, 1, 0});
    tbl.push_back('{1, 1, 0, 3, 3, 0, 12, 1, 0});
    // stall: 15 quiet edges still RUN, the 16th enters STALL
    tbl.push_back('{0, 1, 0, 15, 3, 0, 12, 1, 0});
    tbl.push_back('{0, 1, 0, 1, 3, 0, 12, 0, 1});
    tbl.push_back('{0, 1, 0, 5, 3, 0, 12, 0, 1});
    tbl.push_back('{1, 1, 0, 3, 4, 0, 24, 0, 0});
    tbl.push_back('{0, 1, 0, 9, 4, 0, 24, 0, 0});
    tbl.push_back('{1, 1, 0, 3, 5, 0, 12, 1, 0});
    tbl.push_back('{0, 1, 0, 9, 5, 0, 12, 1, 0});
    // En=0 over three rises: Count holds, Period tracks
    tbl.push_back('{1, 0, 0, 3, 5, 0, 12, 1, 0});
    tbl.push_back('{0, 0, 0, 7, 5, 0, 12, 1, 0});
    tbl.push_back('{1, 0, 0, 3, 5, 0, 10, 1, 0});
    tbl.push_back('{0, 0, 0, 7, 5, 0, 10, 1, 0});
    tbl.push_back('{1, 0, 0, 3, 5, 0, 10, 1, 0});
    tbl.push_back('{0, 0, 0, 7, 5, 0, 10, 1, 0});
    // Clr on the same edge as a rise: rise discarded, back to IDLE
    tbl.push_back('{1, 1, 0, 2, 5, 0, 10, 1, 0});
    tbl.push_back('{1, 1, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 7, 0, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 3, 1, 0, 10, 0, 0});
    tbl.push_back('{0, 1, 0, 7, 1, 0, 10, 0, 0});
    tbl.push_back('{1, 1, 0, 3, 2, 0, 10, 1, 0});
    tbl.push_back('{0, 1, 0, 7, 2, 0, 10, 1, 0});

    Reset = 1'b1;
    T_in = 1'b1;
    En = 1'b1;
    Clr = 1'b0;
    #22;
    chk_all("reset", 0, 0, 0, 0, 0);
    @(negedge Clock);
    T_in = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;

    foreach (tbl[i]) begin
      T_in = tbl[i].t;
      En = tbl[i].en;
      Clr = tbl[i].clr;
      repeat (tbl[i].n) @(posedge Clock);
      @(negedge Clock);
      chk_all($sformatf("vec%0d", i), tbl[i].c, tbl[i].tc, tbl[i].p, tbl[i].pv, tbl[i].st);
    end
    En = 1'b1;
    Clr = 1'b0;

    // bring Count to 7, then assert Reset between edges
    repeat (5) pulse(7);
    chk("pre_reset Count", Count, 7);
    chk("pre_reset Period_valid", Period_valid, 1);
    @(posedge Clock);
    #2 Reset = 1'b1;
    #1 chk_all("async_reset", 0, 0, 0, 0, 0);
    @(negedge Clock);
    Reset = 1'b0;
    pulse(7);
    chk("post_reset arm Count", Count, 1);
    chk("post_reset arm Period_valid", Period_valid, 0);
    pulse(7);
    chk_all("post_reset run", 2, 0, 10, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
